// File: rtl/systolic_pkg.sv
// Shared types and arithmetic for the output-stationary systolic tile engine.
package systolic_pkg;

    // Job sequencing: operand streaming, pipeline flush, row-by-row result drain.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Widest accumulator the add helper can handle (ACCUM_WIDTH must stay below this).
    localparam int ACC_MAX_W = 64;

    // Unsigned add at 'width' bits: wraps modulo 2^width, or clamps at all-ones when sat is set.
    // Both operands are below 2^width, so the 64-bit sum never overflows for width < 64.
    // Clamping is naturally sticky: all-ones plus anything stays all-ones.
    function automatic logic [ACC_MAX_W-1:0] accum_add(
        input logic [ACC_MAX_W-1:0] acc,
        input logic [ACC_MAX_W-1:0] addend,
        input int unsigned          width,
        input bit                   sat
    );
        logic [ACC_MAX_W-1:0] mask;
        logic [ACC_MAX_W-1:0] sum;
        mask = {ACC_MAX_W{1'b1}} >> (ACC_MAX_W - width);
        sum  = acc + addend;
        if (sat && (sum > mask)) begin
            accum_add = mask;
        end else begin
            accum_add = sum & mask;
        end
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: multiplies the operands arriving this cycle into its
// accumulator and forwards them (A to the right, B downward) one cycle later.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int ACCUM_WIDTH = 16,
    parameter int SATURATE    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic [DATA_WIDTH-1:0]  i_a,
    input  logic [DATA_WIDTH-1:0]  i_b,
    output logic [DATA_WIDTH-1:0]  o_a,
    output logic [DATA_WIDTH-1:0]  o_b,
    output logic [ACCUM_WIDTH-1:0] o_acc
);

    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [ACCUM_WIDTH-1:0]  r_acc;
    logic [2*DATA_WIDTH-1:0] w_prod;

    assign w_prod = {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};

    // Forward operands to neighbours and fold this cycle's product into the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            r_a <= i_a;
            r_b <= i_b;
            if (i_clear) begin
                r_acc <= '0;
            end else begin
                r_acc <= ACCUM_WIDTH'(accum_add(ACC_MAX_W'(r_acc), ACC_MAX_W'(w_prod),
                                                ACCUM_WIDTH, SATURATE != 0));
            end
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/systolic_tile_mm.sv
// Streaming N x N output-stationary tile: C = A*B over k_len beats, one A column
// and one B row per accepted beat, results drained one row per handshake.
module systolic_tile_mm
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int ACCUM_WIDTH = 16,
    parameter int N           = 4,
    parameter int MAX_K       = 256,
    parameter int SATURATE    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(MAX_K+1)-1:0] k_len,
    input  logic                       acc_keep,
    input  logic [N*DATA_WIDTH-1:0]    a_data,
    input  logic [N*DATA_WIDTH-1:0]    b_data,
    input  logic                       ab_valid,
    output logic                       ab_ready,
    output logic [N*ACCUM_WIDTH-1:0]   c_data,
    output logic [$clog2(N)-1:0]       c_row,
    output logic                       c_valid,
    input  logic                       c_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int KW = $clog2(MAX_K+1);
    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2*N);

    state_t          r_state;
    logic [KW-1:0]   r_klen;
    logic [KW-1:0]   r_beat;
    logic [FW-1:0]   r_flush;
    logic [RW-1:0]   r_row;
    logic            r_done;

    logic            w_start;
    logic            w_beat;
    logic            w_clear;

    logic [DATA_WIDTH-1:0]  w_aInj   [N];
    logic [DATA_WIDTH-1:0]  w_bInj   [N];
    logic [DATA_WIDTH-1:0]  w_aIn    [N][N];
    logic [DATA_WIDTH-1:0]  w_bIn    [N][N];
    logic [DATA_WIDTH-1:0]  w_aFwd   [N][N];
    logic [DATA_WIDTH-1:0]  w_bFwd   [N][N];
    logic [ACCUM_WIDTH-1:0] w_acc    [N][N];
    logic [DATA_WIDTH-1:0]  w_unusedA[N];
    logic [DATA_WIDTH-1:0]  w_unusedB[N];

    assign w_start = (r_state == IDLE) && start;
    assign w_beat  = (r_state == FEED) && ab_valid;
    assign w_clear = w_start && !acc_keep;

    // Job sequencing: latch the job, count beats, time the flush, walk result rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_klen  <= '0;
            r_beat  <= '0;
            r_flush <= '0;
            r_row   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_klen  <= k_len;
                        r_beat  <= '0;
                        r_flush <= '0;
                        r_row   <= '0;
                        r_state <= (k_len == '0) ? DRAIN : FEED;
                    end
                end
                FEED: begin
                    if (w_beat) begin
                        r_beat <= r_beat + KW'(1);
                        if (r_beat == r_klen - KW'(1)) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    r_flush <= r_flush + FW'(1);
                    if (r_flush == FW'(2*N-2)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (c_ready) begin
                        if (r_row == RW'(N-1)) begin
                            r_row   <= '0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_row <= r_row + RW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Input skew: lane i enters the array i cycles late so A[i][k] and B[k][j] meet at PE(i,j).
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        assign w_aInj[gi] = w_beat ? a_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign w_bInj[gi] = w_beat ? b_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (gi == 0) begin : g_direct
            assign w_aIn[0][0] = w_aInj[0];
            assign w_bIn[0][0] = w_bInj[0];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_aPipe [gi];
            logic [DATA_WIDTH-1:0] r_bPipe [gi];
            // Shift each lane through its own delay line, zeroed on reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < gi; s++) begin
                        r_aPipe[s] <= '0;
                        r_bPipe[s] <= '0;
                    end
                end else begin
                    r_aPipe[0] <= w_aInj[gi];
                    r_bPipe[0] <= w_bInj[gi];
                    for (int s = 1; s < gi; s++) begin
                        r_aPipe[s] <= r_aPipe[s-1];
                        r_bPipe[s] <= r_bPipe[s-1];
                    end
                end
            end
            assign w_aIn[gi][0] = r_aPipe[gi-1];
            assign w_bIn[0][gi] = r_bPipe[gi-1];
        end
    end

    // PE grid: A flows right along a row, B flows down a column.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gj > 0) begin : g_aLink
                assign w_aIn[gi][gj] = w_aFwd[gi][gj-1];
            end
            if (gi > 0) begin : g_bLink
                assign w_bIn[gi][gj] = w_bFwd[gi-1][gj];
            end
            systolic_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACCUM_WIDTH(ACCUM_WIDTH),
                .SATURATE   (SATURATE)
            ) u_pe (
                .clk    (clk),
                .rst    (rst),
                .i_clear(w_clear),
                .i_a    (w_aIn[gi][gj]),
                .i_b    (w_bIn[gi][gj]),
                .o_a    (w_aFwd[gi][gj]),
                .o_b    (w_bFwd[gi][gj]),
                .o_acc  (w_acc[gi][gj])
            );
        end
        assign w_unusedA[gi] = w_aFwd[gi][N-1];
        assign w_unusedB[gi] = w_bFwd[N-1][gi];
    end

    // Present the accumulators of the current drain row as one packed result word.
    always_comb begin
        c_data = '0;
        for (int j = 0; j < N; j++) begin
            c_data[j*ACCUM_WIDTH +: ACCUM_WIDTH] = w_acc[r_row][j];
        end
    end

    assign c_row    = r_row;
    assign c_valid  = (r_state == DRAIN);
    assign ab_ready = (r_state == FEED);
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_systolic_tile_mm.sv
// Directed bench for systolic_tile_mm: three instances (16-bit wrap, 8-bit wrap,
// 8-bit saturate) share one stimulus stream; expectations are hand-derived sums.
module tb_systolic_tile_mm;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  k_len;
    logic        acc_keep;
    logic [15:0] a_data;
    logic [15:0] b_data;
    logic        ab_valid;
    logic        c_ready;

    logic        abReady, cValid, busy, done;
    logic [63:0] cData;
    logic [1:0]  cRow;
    logic        abReadyW, cValidW, busyW, doneW;
    logic [31:0] cDataW;
    logic [1:0]  cRowW;
    logic        abReadyS, cValidS, busyS, doneS;
    logic [31:0] cDataS;
    logic [1:0]  cRowS;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] mA [4][16];
    logic [3:0] mB [16][4];
    int         expC [4][4];

    always #5 clk = ~clk;

    systolic_tile_mm #(.DATA_WIDTH(4), .ACCUM_WIDTH(16), .N(4), .MAX_K(256), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_keep(acc_keep),
        .a_data(a_data), .b_data(b_data), .ab_valid(ab_valid), .ab_ready(abReady),
        .c_data(cData), .c_row(cRow), .c_valid(cValid), .c_ready(c_ready),
        .busy(busy), .done(done));

    systolic_tile_mm #(.DATA_WIDTH(4), .ACCUM_WIDTH(8), .N(4), .MAX_K(256), .SATURATE(0)) dutW (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_keep(acc_keep),
        .a_data(a_data), .b_data(b_data), .ab_valid(ab_valid), .ab_ready(abReadyW),
        .c_data(cDataW), .c_row(cRowW), .c_valid(cValidW), .c_ready(c_ready),
        .busy(busyW), .done(doneW));

    systolic_tile_mm #(.DATA_WIDTH(4), .ACCUM_WIDTH(8), .N(4), .MAX_K(256), .SATURATE(1)) dutS (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_keep(acc_keep),
        .a_data(a_data), .b_data(b_data), .ab_valid(ab_valid), .ab_ready(abReadyS),
        .c_data(cDataS), .c_row(cRowS), .c_valid(cValidS), .c_ready(c_ready),
        .busy(busyS), .done(doneS));

    // Hard stop so a wedged handshake can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic setIdentity();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 16; k++) mA[i][k] = (k < 4) ? 4'(i + k) : 4'd0;
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 4; j++) mB[k][j] = (k == j) ? 4'd1 : 4'd0;
    endtask

    task automatic setAllFifteen();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 16; k++) begin
                mA[i][k] = 4'd15;
                mB[k][i] = 4'd15;
            end
    endtask

    task automatic setDiag3();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 16; k++) begin
                mA[i][k] = (i == k) ? 4'd3 : 4'd0;
                mB[k][i] = (i == k) ? 4'd1 : 4'd0;
            end
    endtask

    task automatic startJob(input int k, input logic keep);
        start    = 1'b1;
        k_len    = 9'(k);
        acc_keep = keep;
        tick();
        start    = 1'b0;
        k_len    = '0;
        acc_keep = 1'b0;
        checkOutput("busy after start", 32'(busy), 32'd1);
        checkOutput("done low after start", 32'(done), 32'd0);
    endtask

    // Stream beats first..last; with bubble set, an invalid garbage cycle precedes each beat.
    task automatic applyStimulus(input int first, input int last, input bit bubble);
        int guard;
        for (int kk = first; kk <= last; kk++) begin
            if (bubble) begin
                ab_valid = 1'b0;
                a_data   = '1;
                b_data   = '1;
                tick();
            end
            for (int l = 0; l < 4; l++) begin
                a_data[l*4 +: 4] = mA[l][kk];
                b_data[l*4 +: 4] = mB[kk][l];
            end
            ab_valid = 1'b1;
            guard = 0;
            while (!abReady && guard < 50) begin
                tick();
                guard++;
            end
            checkOutput($sformatf("ab_ready beat %0d", kk), 32'(abReady), 32'd1);
            checkOutput($sformatf("ab_ready sat beat %0d", kk), 32'(abReadyS), 32'd1);
            tick();
        end
        ab_valid = 1'b0;
        a_data   = '0;
        b_data   = '0;
    endtask

    // From the cycle after the last beat: 2N-1 flush cycles, then the first row.
    task automatic waitLatency();
        repeat (2*N-2) tick();
        checkOutput("c_valid low in flush", 32'(cValid), 32'd0);
        checkOutput("busy in flush", 32'(busy), 32'd1);
        tick();
    endtask

    task automatic checkRow(input int r);
        int e;
        checkOutput($sformatf("c_valid row %0d", r), 32'(cValid), 32'd1);
        checkOutput($sformatf("c_row row %0d", r), 32'(cRow), 32'(r));
        checkOutput($sformatf("c_row wrap8 row %0d", r), 32'(cRowW), 32'(r));
        checkOutput($sformatf("c_valid sat row %0d", r), 32'(cValidS), 32'd1);
        for (int j = 0; j < 4; j++) begin
            e = expC[r][j];
            checkOutput($sformatf("C[%0d][%0d] wrap16", r, j), 32'(cData[j*16 +: 16]), 32'(e % 65536));
            checkOutput($sformatf("C[%0d][%0d] wrap8", r, j), 32'(cDataW[j*8 +: 8]), 32'(e % 256));
            checkOutput($sformatf("C[%0d][%0d] sat8", r, j), 32'(cDataS[j*8 +: 8]), (e > 255) ? 32'd255 : 32'(e));
        end
    endtask

    // Accept all four rows, optionally stalling one row; ends in the done cycle.
    task automatic drainRows(input int stallRow, input int stallCycles);
        c_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            if (r == stallRow) begin
                c_ready = 1'b0;
                repeat (stallCycles) begin
                    checkRow(r);
                    tick();
                end
                c_ready = 1'b1;
            end
            checkRow(r);
            tick();
        end
        c_ready = 1'b0;
        checkOutput("done pulse", 32'(done), 32'd1);
        checkOutput("busy low at done", 32'(busy), 32'd0);
        checkOutput("done pulse wrap8", 32'(doneW), 32'd1);
        checkOutput("done pulse sat8", 32'(doneS), 32'd1);
        checkOutput("c_valid low at done", 32'(cValid), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        k_len    = '0;
        acc_keep = 1'b0;
        ab_valid = 1'b0;
        c_ready  = 1'b0;
        a_data   = '0;
        b_data   = '0;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset ab_ready", 32'(abReady), 32'd0);
        checkOutput("reset c_valid", 32'(cValid), 32'd0);
        checkOutput("reset c_data lo", cData[31:0], 32'd0);
        checkOutput("reset c_data hi", cData[63:32], 32'd0);
        checkOutput("reset c_row", 32'(cRow), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset busy sat", 32'(busyS), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] identity B, A[i][k]=i+k, K=4");
        setIdentity();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) expC[i][j] = i + j;
        startJob(4, 1'b0);
        checkOutput("ab_ready in feed", 32'(abReady), 32'd1);
        applyStimulus(0, 3, 1'b0);
        waitLatency();
        drainRows(-1, 0);

        $display("[TB] all-15 operands, K=16");
        setAllFifteen();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) expC[i][j] = 3600;
        startJob(16, 1'b0);
        applyStimulus(0, 15, 1'b0);
        waitLatency();
        drainRows(-1, 0);

        $display("[TB] 3*I times I, then again with acc_keep");
        setDiag3();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) expC[i][j] = (i == j) ? 3 : 0;
        startJob(4, 1'b0);
        applyStimulus(0, 3, 1'b0);
        waitLatency();
        drainRows(-1, 0);
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) expC[i][j] = (i == j) ? 6 : 0;
        startJob(4, 1'b1);
        applyStimulus(0, 3, 1'b0);
        waitLatency();
        drainRows(-1, 0);

        $display("[TB] bubbles on ab_valid, 5-cycle stall on row 1");
        setIdentity();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) expC[i][j] = i + j;
        startJob(4, 1'b0);
        applyStimulus(0, 3, 1'b1);
        waitLatency();
        drainRows(1, 5);

        $display("[TB] reset in FEED after 2 beats, then fresh job with acc_keep");
        setAllFifteen();
        startJob(4, 1'b0);
        applyStimulus(0, 1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort c_valid", 32'(cValid), 32'd0);
        checkOutput("abort ab_ready", 32'(abReady), 32'd0);
        checkOutput("abort c_row", 32'(cRow), 32'd0);
        checkOutput("abort acc cleared lo", cData[31:0], 32'd0);
        checkOutput("abort acc cleared sat", cDataS, 32'd0);
        setIdentity();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) expC[i][j] = i + j;
        startJob(4, 1'b1);
        applyStimulus(0, 3, 1'b0);
        waitLatency();
        drainRows(-1, 0);

        $display("[TB] start ignored during FEED, then k_len=0 job");
        setIdentity();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) expC[i][j] = (j < 2) ? i + j : 0;
        startJob(2, 1'b0);
        applyStimulus(0, 0, 1'b0);
        start = 1'b1;
        k_len = '0;
        tick();
        start = 1'b0;
        checkOutput("ignored start busy", 32'(busy), 32'd1);
        checkOutput("ignored start ab_ready", 32'(abReady), 32'd1);
        checkOutput("ignored start c_valid", 32'(cValid), 32'd0);
        applyStimulus(1, 1, 1'b0);
        waitLatency();
        drainRows(-1, 0);
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) expC[i][j] = 0;
        startJob(0, 1'b0);
        checkOutput("k0 ab_ready", 32'(abReady), 32'd0);
        drainRows(-1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
